chacha_stream_adapter: RTL
==========================

Name: chacha_stream_adapter

Overview:
- Word-stream front/back end for the 512-bit ChaCha XOR core.
- Packs 32-bit input words into 512-bit blocks and issues the core's init/next start pulses.
- Manages the 64-bit block counter, captures the XORed 512-bit result and re-serialises it as 32-bit output words with valid/ready backpressure.
- Sits between the host word bus and the core: upstream of the core's data_in/ctr, downstream of its data_out.

Parameters:
- RESET_CTR, 64'h0, counter value after reset.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- cfg_load  in  1  load cfg_ctr and mark next block as first (init); honoured only in IDLE
- cfg_ctr  in  64  starting block counter
- in_valid  in  1  input word valid
- in_ready  out  1  adapter accepts input word
- in_data  in  32  input plaintext/ciphertext word
- in_last  in  1  final word of stream
- out_valid  out  1  output word valid
- out_ready  in  1  sink accepts output word
- out_data  out  32  XORed output word
- out_last  out  1  final output word of stream
- core_init  out  1  one-cycle start, first block after cfg_load
- core_next  out  1  one-cycle start, subsequent blocks
- core_ctr  out  64  counter presented to core
- core_data_in  out  512  packed block to core
- core_ready  in  1  core idle
- core_data_out_valid  in  1  core result pulse
- core_data_out  in  512  core result
- busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous on the rising clk edge with reset_n=0, and overrides all other inputs.
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0; out_last=0; out_data=0.
  - core_init=0; core_next=0; core_data_in=0; core_ctr=RESET_CTR; first=1; busy=0.
- Word order: word k (k=0..15) occupies core_data_in[511-32k -: 32]. Output unpacks in the same order.
- States:
  - IDLE: in_ready=1. cfg_load loads core_ctr=cfg_ctr and sets first=1, with no handshake. An accepted word writes slot 0, cnt=1, then goes to FILL. An accepted word with in_last goes directly to ISSUE.
  - FILL: in_ready=1. Each accepted word writes slot cnt and increments cnt. Go to ISSUE when cnt reaches 16 or the accepted word has in_last (latch last_seen). Unfilled slots are zero.
  - ISSUE: in_ready=0. When core_ready=1, register core_init=first (else core_next=1) for exactly one cycle, clear first, and go to WAIT. core_ctr increments by 1 on the cycle after the pulse, wrapping 2^64-1 to 0. core_data_in and core_ctr are stable while the pulse is high.
  - WAIT: capture core_data_out on core_data_out_valid and go to DRAIN with idx=0. core_data_out_valid in any other state is ignored.
  - DRAIN: out_valid=1 and out_data=word idx. Advance only on out_valid&&out_ready. out_last=1 on word cnt-1 when last_seen. After word cnt-1 transfers, go to IDLE, clear last_seen and cnt, and zero the buffer.
- Blocks continue without a new cfg_load: the next block issues core_next with the incremented counter.
- Output registers hold stable while out_valid&&!out_ready.
- Throughput: one input word per cycle. The ISSUE→pulse step takes 1 cycle after core_ready. The drain starts the cycle after core_data_out_valid.
- Boundaries:
  - cfg_load outside IDLE is ignored.
  - in_last on the 16th word is a full block with out_last on word 15.
  - in_valid outside IDLE/FILL is not accepted.
  - Reset mid-operation abandons the block; the core is reset by the same reset_n.

Decomposition:
- Package chacha_pkg holds:
  - CHACHA_BLOCK_W=512, CHACHA_WORD_W=32, CHACHA_WORDS=16, CHACHA_CTR_W=64.
  - State enum: IDLE, FILL, ISSUE, WAIT, DRAIN.
- No sub-module: a single FSM with a 512-bit buffer, a 5-bit cnt and a 4-bit idx.

Test Plan:
- Reset, then cfg_load with cfg_ctr=5, then 16 words 0x00000000..0x0000000F with a core model returning data_in^{16{32'hFFFFFFFF}}:
  - core_init is pulsed once with core_ctr=5.
  - Outputs are 0xFFFFFFFF..0xFFFFFFF0 in order, with out_last=0.
  - core_ctr=6 afterwards.
- 20 words with in_last on word 19:
  - Block 1 uses core_init, ctr=5; block 2 uses core_next, ctr=6.
  - The second block emits 4 words, out_last on the 4th.
  - core_data_in[383:0]=0.
- Hold out_ready=0 for 10 cycles in DRAIN:
  - out_data and out_valid remain stable and no words are lost.
  - in_ready=0 throughout.
- cfg_ctr=64'hFFFFFFFFFFFFFFFF with two blocks: second block core_ctr=0.
- Hold core_ready=0 for 7 cycles in ISSUE: no pulse; a single pulse occurs on the cycle after core_ready rises.
- Assert reset_n=0 in the WAIT state:
  - Next cycle shows IDLE reset values.
  - A later core_data_out_valid produces no output.
  - cfg_load asserted during FILL leaves core_ctr unchanged.

Source files
------------

// File: rtl/chacha_stream_adapter_pkg.sv
// chacha_pkg: shared widths, FSM states and block word helpers for the ChaCha stream adapter
package chacha_pkg;
  localparam int CHACHA_BLOCK_W = 512;
  localparam int CHACHA_WORD_W = 32;
  localparam int CHACHA_WORDS = 16;
  localparam int CHACHA_CTR_W = 64;
  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, DRAIN} state_e;
  function automatic logic [CHACHA_BLOCK_W-1:0] put_word(logic [CHACHA_BLOCK_W-1:0] b, logic [3:0] k,
                                                         logic [CHACHA_WORD_W-1:0] w);
    put_word = b;
    for (int i = 0; i < CHACHA_WORDS; i++)
      if (k == i[3:0]) put_word[CHACHA_BLOCK_W-1-CHACHA_WORD_W*i -: CHACHA_WORD_W] = w;
  endfunction
  function automatic logic [CHACHA_WORD_W-1:0] get_word(logic [CHACHA_BLOCK_W-1:0] b, logic [3:0] k);
    get_word = '0;
    for (int i = 0; i < CHACHA_WORDS; i++)
      if (k == i[3:0]) get_word = b[CHACHA_BLOCK_W-1-CHACHA_WORD_W*i -: CHACHA_WORD_W];
  endfunction
endpackage

// File: rtl/chacha_stream_adapter.sv
// chacha_stream_adapter: packs words into ChaCha blocks, drives core start pulses and re-serialises results
module chacha_stream_adapter
  import chacha_pkg::*;
#(
  parameter logic [CHACHA_CTR_W-1:0] RESET_CTR = 64'h0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_load,
  input  logic [CHACHA_CTR_W-1:0]   cfg_ctr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHACHA_WORD_W-1:0]  in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHACHA_WORD_W-1:0]  out_data,
  output logic                      out_last,
  output logic                      core_init,
  output logic                      core_next,
  output logic [CHACHA_CTR_W-1:0]   core_ctr,
  output logic [CHACHA_BLOCK_W-1:0] core_data_in,
  input  logic                      core_ready,
  input  logic                      core_data_out_valid,
  input  logic [CHACHA_BLOCK_W-1:0] core_data_out,
  output logic                      busy
);
  state_e                    state_q, state_d;
  logic [CHACHA_BLOCK_W-1:0] buf_q, buf_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [3:0]                idx_q, idx_d;
  logic                      first_q, first_d;
  logic                      last_seen_q, last_seen_d;
  logic [CHACHA_CTR_W-1:0]   ctr_q, ctr_d;
  logic                      init_q, init_d;
  logic                      next_q, next_d;
  logic                      at_end;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      buf_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      first_q <= 1'b1;
      last_seen_q <= 1'b0;
      ctr_q <= RESET_CTR;
      init_q <= 1'b0;
      next_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      first_q <= first_d;
      last_seen_q <= last_seen_d;
      ctr_q <= ctr_d;
      init_q <= init_d;
      next_q <= next_d;
    end
  end
  assign in_ready = state_q == IDLE || state_q == FILL;
  assign out_valid = state_q == DRAIN;
  assign at_end = {1'b0, idx_q} == cnt_q - 5'd1;
  assign out_data = out_valid ? get_word(buf_q, idx_q) : '0;
  assign out_last = out_valid && last_seen_q && at_end;
  assign busy = state_q != IDLE;
  assign core_init = init_q;
  assign core_next = next_q;
  assign core_ctr = ctr_q;
  assign core_data_in = buf_q;
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    first_d = first_q;
    last_seen_d = last_seen_q;
    ctr_d = (init_q || next_q) ? ctr_q + 1'b1 : ctr_q;
    init_d = 1'b0;
    next_d = 1'b0;
    case (state_q)
      IDLE, FILL: begin
        if (state_q == IDLE && cfg_load) begin
          ctr_d = cfg_ctr;
          first_d = 1'b1;
        end
        if (in_valid) begin
          buf_d = put_word(buf_q, cnt_q[3:0], in_data);
          cnt_d = cnt_q + 5'd1;
          state_d = (in_last || cnt_q == 5'd15) ? ISSUE : FILL;
          last_seen_d = in_last;
        end
      end
      ISSUE: begin
        if (core_ready) begin
          init_d = first_q;
          next_d = !first_q;
          first_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (core_data_out_valid) begin
          buf_d = core_data_out;
          idx_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          idx_d = idx_q + 4'd1;
          if (at_end) begin
            state_d = IDLE;
            cnt_d = '0;
            idx_d = '0;
            last_seen_d = 1'b0;
            buf_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
